// File: rtl/itch_stream_parser.sv
// -----------------------------------------------------------------------------
// itch_stream_parser
//
// Streaming parser for the packed ITCH-derived order message format. Words
// arrive over a valid/ready handshake; a small FSM with a remaining-word
// counter tracks message boundaries, captures the fields of Add / Cancel /
// Delete / Execute messages, drops messages whose stock locate is not tracked,
// and presents one decoded event per message towards the order book.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_data, i_valid    input stream word and its valid
//   o_ready            parser accepts i_data this cycle (low while emitting)
//   o_valid, i_ready   decoded event handshake towards the order book
//   o_stock_symbol     stock locate of the event
//   o_order_id         order reference
//   o_price            price (Add only, else 0)
//   o_quantity         shares (Add) / affected shares (Cancel, Execute)
//   o_order_type       0=Add 1=Cancel 2=Delete 3=Execute
//   o_side             1=buy (Add only, else 0)
//   o_err_pulse        one-cycle pulse when an unknown header is consumed
//   o_drop_count       saturating count of locate-filtered messages
//   o_err_count        saturating count of unknown headers
// -----------------------------------------------------------------------------
module itch_stream_parser #(
    parameter int REG_WIDTH   = 32,
    parameter int NUM_SYMBOLS = 4,
    parameter int SYM_W       = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1,
    parameter int QTY_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SYM_W-1:0]     o_stock_symbol,
    output logic [REG_WIDTH-1:0] o_order_id,
    output logic [REG_WIDTH-1:0] o_price,
    output logic [QTY_WIDTH-1:0] o_quantity,
    output logic [1:0]           o_order_type,
    output logic                 o_side,
    output logic                 o_err_pulse,
    output logic [CNT_WIDTH-1:0] o_drop_count,
    output logic [CNT_WIDTH-1:0] o_err_count
);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_EMIT} state_t;

    localparam logic [1:0]  T_ADD  = 2'd0;
    localparam logic [1:0]  T_CANC = 2'd1;
    localparam logic [1:0]  T_DEL  = 2'd2;
    localparam logic [1:0]  T_EXEC = 2'd3;
    localparam logic [31:0] LP_NSYM = 32'(NUM_SYMBOLS);

    state_t                 r_state;
    logic [1:0]             r_remain;
    logic [1:0]             r_type;
    logic                   r_side;
    logic [15:0]            r_locate;
    logic [REG_WIDTH-1:0]   r_order_id;
    logic [REG_WIDTH-1:0]   r_price;
    logic [QTY_WIDTH-1:0]   r_qty;
    logic                   r_err_pulse;
    logic [CNT_WIDTH-1:0]   r_drop_count;
    logic [CNT_WIDTH-1:0]   r_err_count;

    logic                   w_known;
    logic [1:0]             w_hdr_type;
    logic [1:0]             w_len_m1;
    logic [1:0]             w_id_slot;
    logic                   w_locate_ok;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Header decode: message type code and remaining word count after W0.
    always_comb begin
        w_known    = 1'b1;
        w_hdr_type = T_ADD;
        w_len_m1   = 2'd3;
        case (i_data[31:24])
            8'h41:   begin w_hdr_type = T_ADD;  w_len_m1 = 2'd3; end
            8'h58:   begin w_hdr_type = T_CANC; w_len_m1 = 2'd2; end
            8'h44:   begin w_hdr_type = T_DEL;  w_len_m1 = 2'd1; end
            8'h45:   begin w_hdr_type = T_EXEC; w_len_m1 = 2'd2; end
            default: begin w_known = 1'b0; end
        endcase
    end

    // The order id is always the first body word, so its counter value
    // depends on the message length.
    always_comb begin
        case (r_type)
            T_ADD:   w_id_slot = 2'd3;
            T_DEL:   w_id_slot = 2'd1;
            default: w_id_slot = 2'd2;
        endcase
    end

    assign w_locate_ok = ({16'd0, r_locate} < LP_NSYM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_remain     <= 2'd0;
            r_type       <= T_ADD;
            r_side       <= 1'b0;
            r_locate     <= 16'd0;
            r_order_id   <= '0;
            r_price      <= '0;
            r_qty        <= '0;
            r_err_pulse  <= 1'b0;
            r_drop_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (w_known) begin
                            r_state    <= S_BODY;
                            r_type     <= w_hdr_type;
                            r_side     <= (w_hdr_type == T_ADD) && (i_data[23:16] == 8'h42);
                            r_locate   <= i_data[15:0];
                            r_remain   <= w_len_m1;
                            // Clear fields so nothing leaks from the previous message.
                            r_order_id <= '0;
                            r_price    <= '0;
                            r_qty      <= '0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_err_count <= sat_inc(r_err_count);
                        end
                    end
                end
                S_BODY: begin
                    if (i_valid) begin
                        r_remain <= r_remain - 2'd1;
                        if (r_remain == w_id_slot)
                            r_order_id <= i_data;
                        if ((r_type == T_ADD) && (r_remain == 2'd2))
                            r_price <= i_data;
                        if ((r_remain == 2'd1) && (r_type != T_DEL))
                            r_qty <= i_data[16 +: QTY_WIDTH];
                        if (r_remain == 2'd1) begin
                            if (w_locate_ok) begin
                                r_state <= S_EMIT;
                            end else begin
                                r_state      <= S_IDLE;
                                r_drop_count <= sat_inc(r_drop_count);
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (i_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready        = (r_state != S_EMIT);
    assign o_valid        = (r_state == S_EMIT);
    assign o_stock_symbol = r_locate[SYM_W-1:0];
    assign o_order_id     = r_order_id;
    assign o_price        = r_price;
    assign o_quantity     = r_qty;
    assign o_order_type   = r_type;
    assign o_side         = r_side;
    assign o_err_pulse    = r_err_pulse;
    assign o_drop_count   = r_drop_count;
    assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_itch_stream_parser.sv
module tb_itch_stream_parser;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [1:0]  o_stock_symbol;
    logic [31:0] o_order_id;
    logic [31:0] o_price;
    logic [15:0] o_quantity;
    logic [1:0]  o_order_type;
    logic        o_side;
    logic        o_err_pulse;
    logic [15:0] o_drop_count;
    logic [15:0] o_err_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]  typ;
        logic [1:0]  sym;
        logic [31:0] id;
        logic [31:0] price;
        logic [15:0] qty;
        logic        side;
    } ev_t;

    ev_t sb[$];

    itch_stream_parser #(
        .REG_WIDTH(32), .NUM_SYMBOLS(4), .SYM_W(2), .QTY_WIDTH(16), .CNT_WIDTH(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
        .o_stock_symbol(o_stock_symbol), .o_order_id(o_order_id), .o_price(o_price),
        .o_quantity(o_quantity), .o_order_type(o_order_type), .o_side(o_side),
        .o_err_pulse(o_err_pulse), .o_drop_count(o_drop_count), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] typ, input logic [1:0] sym, input logic [31:0] id,
                        input logic [31:0] price, input logic [15:0] qty, input logic side);
        ev_t e;
        e.typ = typ; e.sym = sym; e.id = id; e.price = price; e.qty = qty; e.side = side;
        sb.push_back(e);
    endtask

    // Drive one word and hold it until accepted; returns at posedge + 1.
    task automatic send(input logic [31:0] w);
        int t;
        t = 0;
        i_data  = w;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Scoreboard: every completed output handshake is checked against the queue.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_event: observed type %0h id %0h expected none",
                       o_order_type, o_order_id);
            end
            if (sb.size() != 0) begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_type",  32'(o_order_type),   32'(e.typ));
                chk("ev_sym",   32'(o_stock_symbol), 32'(e.sym));
                chk("ev_id",    o_order_id,          e.id);
                chk("ev_price", o_price,             e.price);
                chk("ev_qty",   32'(o_quantity),     32'(e.qty));
                chk("ev_side",  32'(o_side),         32'(e.side));
                chk("ev_ready", 32'(o_ready),        32'd0);
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_errc",  32'(o_err_count), 32'd0);
        chk("rst_dropc", 32'(o_drop_count), 32'd0);
        chk("rst_id",    o_order_id, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Add, buy side, symbol 2
        push(2'd0, 2'd2, 32'h1234, 32'd200, 16'd100, 1'b1);
        send(32'h4142_0002);
        send(32'h0000_1234);
        send(32'h0000_00C8);
        send(32'h0064_0000);
        chk("add_valid_latency", 32'(o_valid), 32'd1);

        // Delete held by downstream backpressure, then Execute
        push(2'd2, 2'd1, 32'h55, 32'd0, 16'd0, 1'b0);
        send(32'h4400_0001);
        i_ready = 1'b0;
        send(32'h0000_0055);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_id",    o_order_id, 32'h55);
            chk("hold_type",  32'(o_order_type), 32'd2);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        push(2'd3, 2'd3, 32'h56, 32'd0, 16'd50, 1'b0);
        send(32'h4500_0003);
        send(32'h0000_0056);
        send(32'h0032_0000);

        // Cancel on untracked locate 7 is dropped; following Add decodes
        send(32'h5800_0007);
        send(32'h0000_0077);
        send(32'h0005_0000);
        chk("drop_count", 32'(o_drop_count), 32'd1);
        chk("drop_no_valid", 32'(o_valid), 32'd0);
        push(2'd0, 2'd1, 32'h99, 32'h1000, 16'd7, 1'b0);
        send(32'h4153_0001);
        send(32'h0000_0099);
        send(32'h0000_1000);
        send(32'h0007_0000);

        // Unknown header then Delete
        send(32'h5A00_0000);
        chk("err_pulse", 32'(o_err_pulse), 32'd1);
        chk("err_count", 32'(o_err_count), 32'd1);
        push(2'd2, 2'd0, 32'hABC, 32'd0, 16'd0, 1'b0);
        send(32'h4400_0000);
        chk("err_pulse_clr", 32'(o_err_pulse), 32'd0);
        send(32'h0000_0ABC);

        // Reset in the middle of an Add
        send(32'h4142_0002);
        send(32'h0000_1111);
        i_rst_n = 1'b0;
        #2;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_errc",  32'(o_err_count), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        chk("postrst_ready", 32'(o_ready), 32'd1);
        push(2'd2, 2'd2, 32'h42, 32'd0, 16'd0, 1'b0);
        send(32'h4400_0002);
        send(32'h0000_0042);

        // Error counter saturation
        for (int k = 0; k < 65534; k++) send(32'h5A00_0000);
        chk("errc_fffe", 32'(o_err_count), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) send(32'h5A00_0000);
        chk("errc_sat", 32'(o_err_count), 32'h0000_FFFF);

        // Drain
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge i_clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
